// File: rtl/breakout_pkg.sv
// breakout_pkg: shared definitions for the breakout game datapath.
//   - bo_state_e : sequencer state encoding (also driven on the state port)
//   - PF_*       : visible playfield bounds
//   - GRID_*     : default brick-grid geometry, shared with block_controller
//   - coord_t    : 11-bit unsigned coordinate used for all position compares
//   - absdiff    : |a - b| without wrap-around
package breakout_pkg;

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_DONE  = 2'd2
  } bo_state_e;

  localparam int unsigned PF_X_MIN = 144;
  localparam int unsigned PF_X_MAX = 783;
  localparam int unsigned PF_Y_MIN = 35;
  localparam int unsigned PF_Y_MAX = 515;

  localparam int unsigned GRID_ROWS    = 5;
  localparam int unsigned GRID_COLS    = 12;
  localparam int unsigned GRID_BRICK_W = 53;
  localparam int unsigned GRID_BRICK_H = 25;
  localparam int unsigned GRID_X0_DEF  = 150;
  localparam int unsigned GRID_Y0_DEF  = 50;

  localparam int unsigned COORD_W = 11;
  typedef logic [COORD_W-1:0] coord_t;

  // Ordered subtraction so the distance never wraps.
  function automatic coord_t absdiff(input coord_t a, input coord_t b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/brick_hit_decoder.sv
// brick_hit_decoder: combinational point-in-brick lookup.
//   nx_i, ny_i  : candidate ball position (11-bit unsigned)
//   alive_i     : brick alive map, bit r*COLS+c
//   hit_o       : (nx_i, ny_i) lies inside at least one alive brick
//   idx_o       : lowest-index alive brick containing the point
// One comparator pair per row and per column; brick membership is the AND
// of its row and column flags, so no division is needed.
module brick_hit_decoder
  import breakout_pkg::*;
#(
  parameter int unsigned ROWS    = GRID_ROWS,
  parameter int unsigned COLS    = GRID_COLS,
  parameter int unsigned BRICK_W = GRID_BRICK_W,
  parameter int unsigned BRICK_H = GRID_BRICK_H,
  parameter int unsigned GRID_X0 = GRID_X0_DEF,
  parameter int unsigned GRID_Y0 = GRID_Y0_DEF,
  localparam int unsigned NB     = ROWS * COLS,
  localparam int unsigned IDX_W  = (NB > 1) ? $clog2(NB) : 1
) (
  input  coord_t               nx_i,
  input  coord_t               ny_i,
  input  logic [NB-1:0]        alive_i,
  output logic                 hit_o,
  output logic [IDX_W-1:0]     idx_o
);

  logic [ROWS-1:0] in_row;
  logic [COLS-1:0] in_col;

  // Inclusive on both edges, matching what the renderer draws; adjacent
  // rows/columns therefore share their boundary line.
  always_comb begin
    in_row = '0;
    for (int r = 0; r < int'(ROWS); r++) begin
      in_row[r] = (ny_i >= COORD_W'(GRID_Y0 + r * BRICK_H)) &&
                  (ny_i <= COORD_W'(GRID_Y0 + (r + 1) * BRICK_H));
    end
  end

  always_comb begin
    in_col = '0;
    for (int c = 0; c < int'(COLS); c++) begin
      in_col[c] = (nx_i >= COORD_W'(GRID_X0 + c * BRICK_W)) &&
                  (nx_i <= COORD_W'(GRID_X0 + (c + 1) * BRICK_W));
    end
  end

  // Scan from the highest index down so the lowest matching index is the
  // one left standing on a shared boundary.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int r = int'(ROWS) - 1; r >= 0; r--) begin
      for (int c = int'(COLS) - 1; c >= 0; c--) begin
        if (alive_i[r * COLS + c] && in_row[r] && in_col[c]) begin
          hit_o = 1'b1;
          idx_o = IDX_W'(r * COLS + c);
        end
      end
    end
  end

endmodule

// File: rtl/breakout_sequencer.sv
// breakout_sequencer: per-frame game state for the breakout playfield.
//   clk, rst     : system clock, synchronous active-high reset
//   frame_tick   : one step of game state per cycle where it is high
//   launch       : serve / restart button level, sampled on ticks only
//   paddle_x     : paddle centre column from block_controller
//   ball_x/y     : registered ball centre
//   brick_alive  : alive map, bit r*COLS+c
//   lives, score : lives remaining, bricks destroyed
//   state        : SERVE=0, PLAY=1, DONE=2
//   won          : DONE was reached by clearing the grid
module breakout_sequencer
  import breakout_pkg::*;
#(
  parameter int unsigned ROWS       = GRID_ROWS,
  parameter int unsigned COLS       = GRID_COLS,
  parameter int unsigned BRICK_W    = GRID_BRICK_W,
  parameter int unsigned BRICK_H    = GRID_BRICK_H,
  parameter int unsigned GRID_X0    = GRID_X0_DEF,
  parameter int unsigned GRID_Y0    = GRID_Y0_DEF,
  parameter int unsigned PADDLE_Y   = 500,
  parameter int unsigned PADDLE_HW  = 25,
  parameter int unsigned PADDLE_HH  = 5,
  parameter int unsigned STEP       = 2,
  parameter int unsigned LIVES_INIT = 3,
  parameter int unsigned X_MIN      = PF_X_MIN,
  parameter int unsigned X_MAX      = PF_X_MAX,
  parameter int unsigned Y_MIN      = PF_Y_MIN,
  parameter int unsigned Y_MAX      = PF_Y_MAX,
  localparam int unsigned NB        = ROWS * COLS,
  localparam int unsigned IDX_W     = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            frame_tick,
  input  logic            launch,
  input  logic [9:0]      paddle_x,
  output logic [9:0]      ball_x,
  output logic [9:0]      ball_y,
  output logic [NB-1:0]   brick_alive,
  output logic [1:0]      lives,
  output logic [6:0]      score,
  output logic [1:0]      state,
  output logic            won
);

  localparam logic [9:0] BALL_X_RST = 10'd450;
  localparam logic [9:0] SERVE_Y    = 10'(PADDLE_Y - 8);
  localparam logic [1:0] LIVES_C    = 2'(LIVES_INIT);
  localparam coord_t     STEP_C     = COORD_W'(STEP);
  localparam coord_t     XMIN_C     = COORD_W'(X_MIN);
  localparam coord_t     XMAX_C     = COORD_W'(X_MAX);
  localparam coord_t     YMIN_C     = COORD_W'(Y_MIN);
  localparam coord_t     YMAX_C     = COORD_W'(Y_MAX);
  localparam coord_t     PY_C       = COORD_W'(PADDLE_Y);
  localparam coord_t     PHW_C      = COORD_W'(PADDLE_HW);
  localparam coord_t     PHH_C      = COORD_W'(PADDLE_HH);

  bo_state_e        state_q, state_d;
  logic [9:0]       bx_q, bx_d, by_q, by_d;
  logic             dx_neg_q, dx_neg_d, dy_neg_q, dy_neg_d;
  logic [NB-1:0]    alive_q, alive_d;
  logic [1:0]       lives_q, lives_d;
  logic [6:0]       score_q, score_d;
  logic             won_q, won_d;

  coord_t           nx, ny;
  logic             brick_hit;
  logic [IDX_W-1:0] brick_idx;
  logic             paddle_hit;

  // Candidate position one step along the current velocity.
  assign nx = dx_neg_q ? ({1'b0, bx_q} - STEP_C) : ({1'b0, bx_q} + STEP_C);
  assign ny = dy_neg_q ? ({1'b0, by_q} - STEP_C) : ({1'b0, by_q} + STEP_C);

  brick_hit_decoder #(
    .ROWS    (ROWS),
    .COLS    (COLS),
    .BRICK_W (BRICK_W),
    .BRICK_H (BRICK_H),
    .GRID_X0 (GRID_X0),
    .GRID_Y0 (GRID_Y0)
  ) u_hit (
    .nx_i    (nx),
    .ny_i    (ny),
    .alive_i (alive_q),
    .hit_o   (brick_hit),
    .idx_o   (brick_idx)
  );

  // Only a descending ball can be returned by the paddle.
  assign paddle_hit = !dy_neg_q &&
                      (absdiff(ny, PY_C) <= PHH_C) &&
                      (absdiff(nx, {1'b0, paddle_x}) <= PHW_C);

  always_comb begin
    state_d  = state_q;
    bx_d     = bx_q;
    by_d     = by_q;
    dx_neg_d = dx_neg_q;
    dy_neg_d = dy_neg_q;
    alive_d  = alive_q;
    lives_d  = lives_q;
    score_d  = score_q;
    won_d    = won_q;
    if (frame_tick) begin
      case (state_q)
        ST_SERVE: begin
          // Ball rides on the paddle until launched.
          bx_d = paddle_x;
          by_d = SERVE_Y;
          if (launch) begin
            dx_neg_d = 1'b0;
            dy_neg_d = 1'b1;
            state_d  = ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (ny >= YMAX_C) begin
            lives_d = lives_q - 2'd1;
            if (lives_d == 2'd0) begin
              state_d = ST_DONE;
              won_d   = 1'b0;
            end else begin
              state_d = ST_SERVE;
            end
          end else if (brick_hit) begin
            alive_d[brick_idx] = 1'b0;
            score_d  = score_q + 7'd1;
            dy_neg_d = ~dy_neg_q;
            bx_d     = nx[9:0];
            if (alive_d == '0) begin
              state_d = ST_DONE;
              won_d   = 1'b1;
            end
          end else if (paddle_hit) begin
            dy_neg_d = 1'b1;
            bx_d     = nx[9:0];
          end else begin
            // Axes bounce independently; a bouncing axis holds its position.
            if ((nx <= XMIN_C) || (nx >= XMAX_C)) dx_neg_d = ~dx_neg_q;
            else                                  bx_d     = nx[9:0];
            if (ny <= YMIN_C) dy_neg_d = ~dy_neg_q;
            else              by_d     = ny[9:0];
          end
        end
        ST_DONE: begin
          if (launch) begin
            state_d  = ST_SERVE;
            bx_d     = paddle_x;
            by_d     = SERVE_Y;
            dx_neg_d = 1'b0;
            dy_neg_d = 1'b1;
            alive_d  = '1;
            lives_d  = LIVES_C;
            score_d  = '0;
            won_d    = 1'b0;
          end
        end
        default: state_d = ST_SERVE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_SERVE;
      bx_q     <= BALL_X_RST;
      by_q     <= SERVE_Y;
      dx_neg_q <= 1'b0;
      dy_neg_q <= 1'b1;
      alive_q  <= '1;
      lives_q  <= LIVES_C;
      score_q  <= '0;
      won_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bx_q     <= bx_d;
      by_q     <= by_d;
      dx_neg_q <= dx_neg_d;
      dy_neg_q <= dy_neg_d;
      alive_q  <= alive_d;
      lives_q  <= lives_d;
      score_q  <= score_d;
      won_q    <= won_d;
    end
  end

  assign ball_x      = bx_q;
  assign ball_y      = by_q;
  assign brick_alive = alive_q;
  assign lives       = lives_q;
  assign score       = score_q;
  assign state       = state_q;
  assign won         = won_q;

endmodule

// File: tb/tb_breakout_sequencer.sv
module tb_breakout_sequencer;

  // Compact grid (2x3) placed low so a full game clears in a few thousand
  // ticks; it spans the whole playfield width so every column is reachable.
  localparam int ROWS = 2, COLS = 3, NB = ROWS * COLS;
  localparam int BW = 214, BH = 40, GX0 = 144, GY0 = 300;
  localparam int PY = 500, PHW = 25, PHH = 5, STEP = 2, LIVES0 = 3;
  localparam int XMIN = 144, XMAX = 783, YMIN = 35, YMAX = 515;
  localparam int S_SERVE = 0, S_PLAY = 1, S_DONE = 2;

  logic          clk = 1'b0;
  logic          rst, frame_tick, launch;
  logic [9:0]    paddle_x, ball_x, ball_y;
  logic [NB-1:0] brick_alive;
  logic [1:0]    lives, state;
  logic [6:0]    score;
  logic          won;

  always #5 clk = ~clk;

  breakout_sequencer #(
    .ROWS    (ROWS),
    .COLS    (COLS),
    .BRICK_W (BW),
    .BRICK_H (BH),
    .GRID_X0 (GX0),
    .GRID_Y0 (GY0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_tick  (frame_tick),
    .launch      (launch),
    .paddle_x    (paddle_x),
    .ball_x      (ball_x),
    .ball_y      (ball_y),
    .brick_alive (brick_alive),
    .lives       (lives),
    .score       (score),
    .state       (state),
    .won         (won)
  );

  typedef struct packed {
    logic [9:0]    bx;
    logic [9:0]    by;
    logic [NB-1:0] alive;
    logic [1:0]    lives;
    logic [6:0]    score;
    logic [1:0]    st;
    logic          won;
  } snap_t;

  snap_t exp_q[$];

  int n_chk = 0;
  int n_pass = 0;

  // Reference game model, plain integer arithmetic.
  int            m_st, m_bx, m_by, m_dx, m_dy, m_lives, m_score;
  bit            m_won;
  logic [NB-1:0] m_alive;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_st = S_SERVE; m_bx = 450; m_by = PY - 8; m_dx = STEP; m_dy = -STEP;
    m_alive = '1; m_lives = LIVES0; m_score = 0; m_won = 1'b0;
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_step(input bit r, input bit t, input bit l, input int px);
    int nx, ny, hit, top, left;
    if (r) begin model_reset(); return; end
    if (!t) return;
    case (m_st)
      S_SERVE: begin
        m_bx = px; m_by = PY - 8;
        if (l) begin m_dx = STEP; m_dy = -STEP; m_st = S_PLAY; end
      end
      S_PLAY: begin
        nx = m_bx + m_dx;
        ny = m_by + m_dy;
        hit = -1;
        for (int i = 0; i < NB; i++) begin
          top  = GY0 + (i / COLS) * BH;
          left = GX0 + (i % COLS) * BW;
          if (hit < 0 && m_alive[i] && ny >= top && ny <= top + BH &&
              nx >= left && nx <= left + BW) hit = i;
        end
        if (ny >= YMAX) begin
          m_lives = m_lives - 1;
          if (m_lives == 0) begin m_st = S_DONE; m_won = 1'b0; end
          else m_st = S_SERVE;
        end else if (hit >= 0) begin
          m_alive[hit] = 1'b0;
          m_score = m_score + 1;
          m_dy = -m_dy;
          m_bx = nx;
          if (m_alive == '0) begin m_st = S_DONE; m_won = 1'b1; end
        end else if (m_dy > 0 && iabs(ny - PY) <= PHH && iabs(nx - px) <= PHW) begin
          m_dy = -STEP;
          m_bx = nx;
        end else begin
          if (nx <= XMIN || nx >= XMAX) m_dx = -m_dx; else m_bx = nx;
          if (ny <= YMIN) m_dy = -m_dy; else m_by = ny;
        end
      end
      default: begin
        if (l) begin model_reset(); m_bx = px; end
      end
    endcase
  endtask

  task automatic cycle(input bit r, input bit t, input bit l, input int px);
    snap_t s, e;
    rst = r; frame_tick = t; launch = l; paddle_x = 10'(px);
    model_step(r, t, l, px);
    s.bx = 10'(m_bx); s.by = 10'(m_by); s.alive = m_alive;
    s.lives = 2'(m_lives); s.score = 7'(m_score); s.st = 2'(m_st); s.won = m_won;
    exp_q.push_back(s);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    check_eq("ball_x", ball_x, e.bx);
    check_eq("ball_y", ball_y, e.by);
    check_eq("brick_alive", brick_alive, e.alive);
    check_eq("lives", lives, e.lives);
    check_eq("score", score, e.score);
    check_eq("state", state, e.st);
    check_eq("won", won, e.won);
    if (n_chk - n_pass > 100) begin
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
    end
  endtask

  task automatic serve();
    int n = 0;
    while (m_st == S_SERVE && n < 60) begin
      cycle(1'b0, $urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0,
            300 + int'($urandom_range(0, 300)));
      n++;
    end
    check_eq("left_serve", 64'(state != 2'd0), 64'd1);
  endtask

  // miss=1 keeps the paddle far from the ball; miss=0 tracks it.
  task automatic play(input bit miss, input int max_cyc, input bit to_exit);
    int n = 0;
    int px;
    while (m_st == S_PLAY && n < max_cyc) begin
      if (miss) px = (m_bx < 464) ? 750 : 200;
      else      px = m_bx + int'($urandom_range(0, 40)) - 20;
      cycle(1'b0, $urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1, px);
      n++;
    end
    if (to_exit) check_eq("left_play", 64'(state != 2'd1), 64'd1);
  endtask

  initial begin
    rst = 1'b1; frame_tick = 1'b0; launch = 1'b0; paddle_x = 10'd450;
    model_reset();

    cycle(1'b1, 1'b0, 1'b0, 450);
    cycle(1'b1, 1'b1, 1'b1, 450);
    check_eq("rst_state", state, 2'd0);
    check_eq("rst_ball_x", ball_x, 450);
    check_eq("rst_ball_y", ball_y, 492);
    check_eq("rst_lives", lives, 3);

    // launch without a tick does nothing
    repeat (3) cycle(1'b0, 1'b0, 1'b1, 600);

    // serve from 450 and take the first step
    cycle(1'b0, 1'b1, 1'b1, 450);
    check_eq("launch_state", state, 2'd1);
    cycle(1'b0, 1'b1, 1'b0, 450);
    check_eq("first_step_x", ball_x, 452);
    check_eq("first_step_y", ball_y, 490);

    // one deliberate miss, then clear the grid
    play(1'b1, 2000, 1'b1);
    check_eq("miss_lives", lives, 2);
    check_eq("miss_state", state, 2'd0);
    serve();
    play(1'b0, 40000, 1'b1);
    check_eq("clear_won", won, 1);
    check_eq("clear_score", score, NB);
    check_eq("clear_state", state, 2'd2);
    check_eq("clear_alive", brick_alive, '0);

    // DONE holds, then restart
    repeat (4) cycle(1'b0, 1'b1, 1'b0, 200 + int'($urandom_range(0, 400)));
    cycle(1'b0, 1'b1, 1'b1, 333);
    check_eq("restart_alive", brick_alive, {NB{1'b1}});
    check_eq("restart_lives", lives, 3);
    check_eq("restart_score", score, 0);
    check_eq("restart_ball_x", ball_x, 333);

    // lose every life
    repeat (3) begin
      serve();
      play(1'b1, 3000, 1'b1);
    end
    check_eq("lost_state", state, 2'd2);
    check_eq("lost_won", won, 0);
    check_eq("lost_lives", lives, 0);

    // restart and reset mid-play on a tick
    cycle(1'b0, 1'b1, 1'b1, 400);
    serve();
    play(1'b0, 150, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, m_bx);
    check_eq("midrst_state", state, 2'd0);
    check_eq("midrst_ball_x", ball_x, 450);
    check_eq("midrst_ball_y", ball_y, 492);
    check_eq("midrst_score", score, 0);
    check_eq("midrst_alive", brick_alive, {NB{1'b1}});
    repeat (5) cycle(1'b0, 1'b1, 1'b0, 500);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
